// File: rtl/hazard_controller.sv
//------------------------------------------------------------------------------
// HazardController (module hazard_controller)
//
// Central pipeline sequencer for the five-stage core. It drives the stall of
// the fetch stage / PC and the bubble and flush controls of the IF/ID and
// ID/EX pipeline registers.
//
// Responsibilities:
//   - hold the pipeline for a boot window after reset so the synchronous
//     instruction memory can deliver its first word,
//   - detect load-use hazards and insert one bubble per hazard cycle,
//   - squash IF/ID and ID/EX on a taken branch resolved in EX,
//   - provide a debug halt / single-step / resume handshake,
//   - keep a saturating count of hazard stall cycles.
//
// Parameters:
//   BOOT_CYCLES : cycles the pipeline is held after reset release (1..255)
//   CNT_W       : width of the stall-cycle counter
//
// Ports:
//   clk_i                 : clock, all state updates on the rising edge
//   rst_i                 : synchronous active-high reset
//   id_rs1_i, id_rs2_i    : source register indices of the ID instruction
//   id_uses_rs1_i/rs2_i   : the ID instruction really reads rs1 / rs2
//   ex_rd_i               : destination register of the EX instruction
//   ex_mem_read_i         : the EX instruction is a load
//   ex_if_take_branch_i   : EX resolved a taken branch or jump this cycle
//   dbg_halt_req_i        : debug halt request (level)
//   dbg_step_req_i        : debug single-step request (level)
//   dbg_resume_req_i      : debug resume request (level)
//   stall_o               : freeze PC and IF/ID
//   id_ex_bubble_o        : load a NOP into ID/EX
//   flush_if_id_o         : squash IF/ID
//   flush_id_ex_o         : squash ID/EX
//   dbg_halted_o          : registered, high while the core is halted
//   dbg_step_done_o       : registered one-cycle pulse when a step completes
//   stall_cycles_o        : saturating count of hazard stall cycles
//------------------------------------------------------------------------------
module hazard_controller #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_if_take_branch_i,

    input  logic             dbg_halt_req_i,
    input  logic             dbg_step_req_i,
    input  logic             dbg_resume_req_i,

    output logic             stall_o,
    output logic             id_ex_bubble_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,

    output logic             dbg_halted_o,
    output logic             dbg_step_done_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    //--------------------------------------------------------------------------
    // State encoding
    //--------------------------------------------------------------------------
    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;

    // The boot counter runs from 0 up to BOOT_CYCLES-1; the last boot cycle
    // is the one in which the counter holds this value.
    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    //--------------------------------------------------------------------------
    // Registers and next-state values
    //--------------------------------------------------------------------------
    logic [1:0]       state_q,        state_d;
    logic [7:0]       boot_cnt_q,     boot_cnt_d;
    logic             halt_pending_q, halt_pending_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             dbg_halted_q,   dbg_halted_d;
    logic             step_done_q,    step_done_d;

    //--------------------------------------------------------------------------
    // Hazard detection
    //--------------------------------------------------------------------------
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic branch;
    logic hold_hazard;

    // A load into x0 never produces a value, so it cannot create a hazard.
    // A taken branch squashes the ID instruction, which makes any load-use
    // dependency of that instruction irrelevant: the branch wins and no stall
    // is raised.
    always_comb begin
        rs1_hit     = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_hit     = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
        load_use    = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
        branch      = ex_if_take_branch_i;
        hold_hazard = load_use && !branch;
    end

    //--------------------------------------------------------------------------
    // Pipeline control outputs
    //--------------------------------------------------------------------------
    // These are purely combinational so the pipeline reacts in the same cycle.
    // The safe default (frozen front end, NOP into ID/EX, no flush) covers
    // reset, BOOT and HALTED. Reset overrides the state because the state
    // register only reaches BOOT on the first reset edge.
    always_comb begin
        stall_o        = 1'b1;
        id_ex_bubble_o = 1'b1;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_RUN, ST_STEP: begin
                    stall_o        = hold_hazard;
                    id_ex_bubble_o = hold_hazard;
                    flush_if_id_o  = branch;
                    flush_id_ex_o  = branch;
                end
                default: begin
                    stall_o        = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Sequencer next-state logic
    //--------------------------------------------------------------------------
    // BOOT counts out the boot window and remembers any halt request seen on
    // the way so the core can come up directly halted. RUN only accepts a halt
    // in a hazard-free cycle, so a stalled or squashed instruction is never
    // left half-done when the debugger takes over. STEP lets exactly one
    // non-stalled advance through; it lingers while a load-use hazard holds
    // the pipeline and then returns to HALTED with a done pulse.
    always_comb begin
        state_d        = state_q;
        boot_cnt_d     = boot_cnt_q;
        halt_pending_d = halt_pending_q;
        step_done_d    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + 8'd1;
                if (dbg_halt_req_i) begin
                    halt_pending_d = 1'b1;
                end
                if (boot_cnt_q == BOOT_LAST) begin
                    boot_cnt_d     = 8'd0;
                    halt_pending_d = 1'b0;
                    if (halt_pending_q || dbg_halt_req_i) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (dbg_halt_req_i && !branch && !load_use) begin
                    state_d = ST_HALTED;
                end
            end

            ST_HALTED: begin
                if (dbg_resume_req_i) begin
                    state_d = ST_RUN;
                end else if (dbg_step_req_i) begin
                    state_d = ST_STEP;
                end
            end

            ST_STEP: begin
                if (!hold_hazard) begin
                    state_d     = ST_HALTED;
                    step_done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Registered view of the halted state, aligned with the state register.
        dbg_halted_d = (state_d == ST_HALTED);
    end

    //--------------------------------------------------------------------------
    // Stall-cycle counter
    //--------------------------------------------------------------------------
    // Only hazard stalls in RUN or STEP are counted; the boot window and the
    // halted state hold the pipeline for other reasons. The counter sticks at
    // all-ones instead of wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (((state_q == ST_RUN) || (state_q == ST_STEP)) && hold_hazard &&
            (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    // Reset aborts whatever is in flight, including a step in progress, so the
    // done pulse is cleared rather than allowed to fire.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_BOOT;
            boot_cnt_q     <= 8'd0;
            halt_pending_q <= 1'b0;
            stall_cycles_q <= '0;
            dbg_halted_q   <= 1'b0;
            step_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            boot_cnt_q     <= boot_cnt_d;
            halt_pending_q <= halt_pending_d;
            stall_cycles_q <= stall_cycles_d;
            dbg_halted_q   <= dbg_halted_d;
            step_done_q    <= step_done_d;
        end
    end

    //--------------------------------------------------------------------------
    // Registered outputs
    //--------------------------------------------------------------------------
    assign dbg_halted_o    = dbg_halted_q;
    assign dbg_step_done_o = step_done_q;
    assign stall_cycles_o  = stall_cycles_q;

endmodule

// File: tb/tb_hazard_controller.sv
//------------------------------------------------------------------------------
// TbHazardController (module tb_hazard_controller)
//
// Directed bench for hazard_controller with BOOT_CYCLES=2 and a 4-bit stall
// counter so saturation is reachable quickly. Inputs change 1 time unit after
// a rising edge; combinational outputs are observed after they settle and
// registered outputs 1 time unit after the edge that updates them.
//------------------------------------------------------------------------------
module tb_hazard_controller;

    localparam int BOOT_CYCLES = 2;
    localparam int CNT_W       = 4;

    logic             clock;
    logic             rst;
    logic [4:0]       idRs1;
    logic [4:0]       idRs2;
    logic             idUsesRs1;
    logic             idUsesRs2;
    logic [4:0]       exRd;
    logic             exMemRead;
    logic             exTakeBranch;
    logic             haltReq;
    logic             stepReq;
    logic             resumeReq;
    logic             stall;
    logic             idExBubble;
    logic             flushIfId;
    logic             flushIdEx;
    logic             dbgHalted;
    logic             dbgStepDone;
    logic [CNT_W-1:0] stallCycles;

    int checkCount;
    int errorCount;

    hazard_controller #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i               (clock),
        .rst_i               (rst),
        .id_rs1_i            (idRs1),
        .id_rs2_i            (idRs2),
        .id_uses_rs1_i       (idUsesRs1),
        .id_uses_rs2_i       (idUsesRs2),
        .ex_rd_i             (exRd),
        .ex_mem_read_i       (exMemRead),
        .ex_if_take_branch_i (exTakeBranch),
        .dbg_halt_req_i      (haltReq),
        .dbg_step_req_i      (stepReq),
        .dbg_resume_req_i    (resumeReq),
        .stall_o             (stall),
        .id_ex_bubble_o      (idExBubble),
        .flush_if_id_o       (flushIfId),
        .flush_id_ex_o       (flushIdEx),
        .dbg_halted_o        (dbgHalted),
        .dbg_step_done_o     (dbgStepDone),
        .stall_cycles_o      (stallCycles)
    );

    // 10 time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives the hazard-related inputs and lets the combinational outputs settle.
    task automatic applyStimulus(input logic memRead, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic use1,
                                 input logic [4:0] rs2, input logic use2,
                                 input logic br);
        exMemRead    = memRead;
        exRd         = rd;
        idRs1        = rs1;
        idUsesRs1    = use1;
        idRs2        = rs2;
        idUsesRs2    = use2;
        exTakeBranch = br;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advances to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        rst          = 1'b1;
        haltReq      = 1'b0;
        stepReq      = 1'b0;
        resumeReq    = 1'b0;
        applyIdle();

        // ---------------- reset values ----------------
        tick();
        tick();
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        checkOutput("rst stall",     stall,       1);
        checkOutput("rst bubble",    idExBubble,  1);
        checkOutput("rst flushIfId", flushIfId,   0);
        checkOutput("rst flushIdEx", flushIdEx,   0);
        checkOutput("rst halted",    dbgHalted,   0);
        checkOutput("rst stepDone",  dbgStepDone, 0);
        checkOutput("rst count",     stallCycles, 0);
        applyIdle();

        // ---------------- boot window ----------------
        rst = 1'b0;
        #1;
        checkOutput("boot c0 stall", stall, 1);
        tick();
        checkOutput("boot c1 stall", stall, 1);
        tick();
        checkOutput("boot c2 stall",  stall,       0);
        checkOutput("boot c2 halted", dbgHalted,   0);
        checkOutput("boot c2 count",  stallCycles, 0);

        // ---------------- load-use on rs2 ----------------
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        checkOutput("lu rs2 stall",  stall,      1);
        checkOutput("lu rs2 bubble", idExBubble, 1);
        checkOutput("lu rs2 flush",  flushIfId,  0);
        tick();
        checkOutput("lu rs2 count", stallCycles, 1);

        // Load into x0 is never a hazard.
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        checkOutput("lu x0 stall", stall, 0);
        tick();
        checkOutput("lu x0 count", stallCycles, 1);

        // Load-use through rs1, and the same registers with the use flag low.
        applyStimulus(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("lu rs1 unused stall", stall, 0);
        applyStimulus(1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("lu rs1 stall", stall, 1);
        tick();
        checkOutput("lu rs1 count", stallCycles, 2);

        // ---------------- branch beats load-use ----------------
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        checkOutput("br flushIfId", flushIfId,  1);
        checkOutput("br flushIdEx", flushIdEx,  1);
        checkOutput("br stall",     stall,      0);
        checkOutput("br bubble",    idExBubble, 0);
        tick();
        checkOutput("br count", stallCycles, 2);

        // ---------------- halt waits for hazard-free cycle ----------------
        haltReq = 1'b1;
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        checkOutput("halt blocked halted", dbgHalted,   0);
        checkOutput("halt blocked count",  stallCycles, 3);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        checkOutput("halt blocked by br", dbgHalted, 0);
        applyIdle();
        checkOutput("halt accept stall", stall, 0);
        tick();
        haltReq = 1'b0;
        checkOutput("halted", dbgHalted, 1);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("halted stall", stall,     1);
        checkOutput("halted flush", flushIfId, 0);
        applyIdle();
        tick();
        checkOutput("halted hold", dbgHalted, 1);

        // ---------------- single step, no hazard ----------------
        stepReq = 1'b1;
        tick();
        stepReq = 1'b0;
        checkOutput("step stall",    stall,       0);
        checkOutput("step halted",   dbgHalted,   0);
        checkOutput("step done pre", dbgStepDone, 0);
        tick();
        checkOutput("step done",        dbgStepDone, 1);
        checkOutput("step back halted", dbgHalted,   1);
        tick();
        checkOutput("step done clears", dbgStepDone, 0);

        // ---------------- single step stretched by load-use ----------------
        stepReq = 1'b1;
        tick();
        stepReq = 1'b0;
        applyStimulus(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("step lu stall", stall, 1);
        tick();
        checkOutput("step lu done",  dbgStepDone, 0);
        checkOutput("step lu count", stallCycles, 4);
        applyIdle();
        checkOutput("step lu release", stall, 0);
        tick();
        checkOutput("step lu done late", dbgStepDone, 1);
        checkOutput("step lu halted",    dbgHalted,   1);

        // ---------------- resume wins over step ----------------
        resumeReq = 1'b1;
        stepReq   = 1'b1;
        tick();
        resumeReq = 1'b0;
        stepReq   = 1'b0;
        checkOutput("resume halted",   dbgHalted,   0);
        checkOutput("resume stall",    stall,       0);
        checkOutput("resume stepDone", dbgStepDone, 0);

        // ---------------- counter saturation ----------------
        applyStimulus(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checkOutput("sat count", stallCycles, 15);
        applyIdle();

        // ---------------- halt during boot ----------------
        rst = 1'b1;
        tick();
        checkOutput("reboot count", stallCycles, 0);
        rst     = 1'b0;
        haltReq = 1'b1;
        #1;
        tick();
        haltReq = 1'b0;
        checkOutput("bh c1 stall", stall, 1);
        tick();
        checkOutput("bh c2 stall",  stall,     1);
        checkOutput("bh c2 halted", dbgHalted, 1);
        tick();
        checkOutput("bh c3 stall", stall, 1);

        // ---------------- reset during step ----------------
        stepReq = 1'b1;
        tick();
        stepReq = 1'b0;
        checkOutput("rs step stall", stall, 0);
        rst = 1'b1;
        #1;
        checkOutput("rs rst stall", stall, 1);
        tick();
        checkOutput("rs stepDone", dbgStepDone, 0);
        checkOutput("rs halted",   dbgHalted,   0);
        checkOutput("rs bubble",   idExBubble,  1);
        rst = 1'b0;
        #1;
        tick();
        checkOutput("rs stepDone after", dbgStepDone, 0);
        checkOutput("rs boot stall",     stall,       1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
